// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Conditions raw active-low push-buttons for the stopwatch counter FSM.
//   Each key is synchronised through two flops and then debounced by its own
//   stability FSM. A change is committed only after the synchronised sample
//   has held the new value for DEBOUNCE_CYCLES consecutive cycles. A commit
//   produces a clean level and a one-cycle press or release strobe. The block
//   also remembers the code of the last committed press.
//
//   State table (per key):
//     state | meaning
//     REL   | debounced level released (1), waiting for a 0 sample
//     CHK_P | candidate press, counting stable 0 samples
//     HELD  | debounced level pressed (0), waiting for a 1 sample
//     CHK_R | candidate release, counting stable 1 samples
//
// Ports
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   key_n        in   N_KEYS  raw buttons, active-low, asynchronous to clk
//   key_level_n  out  N_KEYS  debounced level, active-low (1 = released)
//   key_press    out  N_KEYS  one-cycle strobe on a committed press
//   key_release  out  N_KEYS  one-cycle strobe on a committed release
//   key_any_n    out  1       0 while any debounced key is held
//   key_id       out  3       last committed press: 0..3 = KEY0..KEY3, 4 = none
// -----------------------------------------------------------------------------
module key_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level_n,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              key_any_n,
    output logic [2:0]        key_id
);

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        HELD  = 2'd2,
        CHK_R = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       ID_NONE  = 3'd4;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sample;
    logic [N_KEYS-1:0] level_nx;
    logic [N_KEYS-1:0] press_nx;
    logic [N_KEYS-1:0] release_nx;
    logic [2:0]        id_nx;

    // Two-flop synchroniser; idle (released) value is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '1;
            sample <= '1;
        end else begin
            sync1  <= key_n;
            sample <= sync1;
        end
    end

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             lvl_d;
        logic             press_d;
        logic             release_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= REL;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // The bounce test comes before the terminal-count test, so a commit
        // needs the new value on every sample of the window, including the last.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            lvl_d     = key_level_n[gi];
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                REL: begin
                    if (!sample[gi]) begin
                        cnt_d   = '0;
                        state_d = CHK_P;
                    end
                end
                CHK_P: begin
                    if (sample[gi]) begin
                        state_d = REL;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        lvl_d   = 1'b0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (sample[gi]) begin
                        cnt_d   = '0;
                        state_d = CHK_R;
                    end
                end
                CHK_R: begin
                    if (!sample[gi]) begin
                        state_d = HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = REL;
                        lvl_d     = 1'b1;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = REL;
                end
            endcase
        end

        assign level_nx[gi]   = lvl_d;
        assign press_nx[gi]   = press_d;
        assign release_nx[gi] = release_d;
    end

    // Scan from the highest index down so the lowest pressing index wins.
    always_comb begin
        id_nx = key_id;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (press_nx[i]) begin
                id_nx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_level_n <= '1;
            key_press   <= '0;
            key_release <= '0;
            key_id      <= ID_NONE;
        end else begin
            key_level_n <= level_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
            key_id      <= id_nx;
        end
    end

    assign key_any_n = &key_level_n;

endmodule
